// File: rtl/iter_normalizer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iter_normalizer_if                                           |
// | Description : Handshake bundle for iter_normalizer. It carries the input   |
// |               word channel (valid/ready/data) and the result channel       |
// |               (valid/ready/data/shift/zero).                               |
// | Ports       : master - drives the input word and out_ready (source/sink)   |
// |               slave  - drives in_ready and the result (normalizer side)    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface iter_normalizer_if #(
  parameter int WIDTH = 8
);
  localparam int LOG2 = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [LOG2-1:0]  shift_amt;
  logic             zero;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, shift_amt, zero
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, shift_amt, zero
  );
endinterface
`default_nettype wire

// File: rtl/iter_normalizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iter_normalizer                                              |
// | Description : Iterative leading-zero normalizer. An accepted word is       |
// |               shifted left in LOG2 binary-search stages (WIDTH/2 ... 1),   |
// |               one stage per cycle, until its MSB is set. The result holds  |
// |               until the downstream handshake completes.                    |
// | Ports       : clk  - rising-edge clock                                     |
// |               rst  - synchronous active-high reset                         |
// |               bus  - slave modport: in_valid/in_ready/data_in in,          |
// |                      out_valid/out_ready/data_out/shift_amt/zero out       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module iter_normalizer #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  iter_normalizer_if.slave   bus
);
  localparam int LOG2 = $clog2(WIDTH);

  // First stage distance and index of the final stage.
  localparam logic [LOG2-1:0] HALF_DIST  = LOG2'(WIDTH / 2);
  localparam logic [LOG2-1:0] LAST_STAGE = LOG2'(LOG2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [LOG2-1:0]  cnt_q,   cnt_d;
  logic [LOG2-1:0]  stage_q, stage_d;
  logic             zero_q,  zero_d;

  logic [LOG2-1:0]  dist_w;
  logic [WIDTH-1:0] mask_w;
  logic             top_zero_w;

  // Stage distance halves each cycle; the mask selects the top dist_w bits.
  assign dist_w     = HALF_DIST >> stage_q;
  assign mask_w     = ~({WIDTH{1'b1}} >> dist_w);
  assign top_zero_w = ((work_q & mask_w) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.data_in;
          cnt_d   = '0;
          stage_d = '0;
          zero_d  = (bus.data_in == '0);
          state_d = BUSY;
        end
      end

      BUSY: begin
        // An all-zero word shifts at every stage, so the count naturally
        // saturates at WIDTH-1 without any special case.
        if (top_zero_w) begin
          work_d = work_q << dist_w;
          cnt_d  = cnt_q + dist_w;
        end
        stage_d = stage_q + LOG2'(1);
        if (stage_q == LAST_STAGE) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.data_out  = work_q;
  assign bus.shift_amt = cnt_q;
  assign bus.zero      = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_iter_normalizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_iter_normalizer                                           |
// | Description : Scoreboard bench for iter_normalizer (WIDTH=8). Accepted     |
// |               words are pushed through a leading-zero reference model     |
// |               into a queue; a monitor pops on every output handshake.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_iter_normalizer;
  localparam int W = 8;
  localparam int L = 3;

  typedef struct packed {
    logic [W-1:0] data;
    logic [L-1:0] sh;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iter_normalizer_if #(.WIDTH(W)) bus ();

  iter_normalizer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t exp_q[$];
  res_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_sent  = 0;
  int   n_recv  = 0;

  // Reference: count leading zeros by scanning from the MSB.
  function automatic res_t ref_model(input logic [W-1:0] d);
    res_t r;
    int   lz;
    if (d == '0) begin
      r.data = '0;
      r.sh   = L'(W - 1);
      r.z    = 1'b1;
    end else begin
      lz = 0;
      while (d[W-1-lz] == 1'b0) lz++;
      r.data = d << lz;
      r.sh   = L'(lz);
      r.z    = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples handshakes at the active edge (pre-update values).
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_model(bus.data_in));
        n_sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_data_out",  32'(bus.data_out),  32'(mon_e.data));
          check("sb_shift_amt", 32'(bus.shift_amt), 32'(mon_e.sh));
          check("sb_zero",      32'(bus.zero),      32'(mon_e.z));
          n_recv++;
        end
      end
    end
  end

  // Single word with out_ready high; checks latency and returned values.
  task automatic run_one(input logic [W-1:0] d, input logic [W-1:0] eo,
                         input logic [L-1:0] es, input logic ez);
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.data_in   = 8'hFF;
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < L; i++) begin
      check("early_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    check("done_out_valid", 32'(bus.out_valid), 32'd1);
    check("done_data_out",  32'(bus.data_out),  32'(eo));
    check("done_shift_amt", 32'(bus.shift_amt), 32'(es));
    check("done_zero",      32'(bus.zero),      32'(ez));
    @(negedge clk);
    check("post_hs_in_ready",  32'(bus.in_ready),  32'd1);
    check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_data_out"},  32'(bus.data_out),  32'd0);
    check({tag, "_shift_amt"}, 32'(bus.shift_amt), 32'd0);
    check({tag, "_zero"},      32'(bus.zero),      32'd0);
  endtask

  initial begin
    int          cyc;
    int          base_s;
    int          base_r;
    logic [W-1:0] v;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Accept in the very first cycle after reset release.
    rst = 1'b0;
    run_one(8'h13, 8'h98, 3'd3, 1'b0);
    run_one(8'h01, 8'h80, 3'd7, 1'b0);
    run_one(8'h80, 8'h80, 3'd0, 1'b0);
    run_one(8'h00, 8'h00, 3'd7, 1'b1);

    // Backpressure: outputs hold, 0xFF pulses on the input are ignored.
    bus.in_valid  = 1'b1;
    bus.data_in   = 8'h05;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_reached_done", 32'(bus.out_valid), 32'd1);
    base_r = n_recv;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.data_in  = 8'hFF;
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_data_out",  32'(bus.data_out),  32'hA0);
      check("bp_shift_amt", 32'(bus.shift_amt), 32'd5);
      check("bp_zero",      32'(bus.zero),      32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_one_handshake", 32'(n_recv - base_r), 32'd1);

    // Reset in the middle of BUSY discards the word.
    bus.in_valid = 1'b1;
    bus.data_in  = 8'h01;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midbusy_reset");
    rst = 1'b0;
    run_one(8'h40, 8'h80, 3'd1, 1'b0);

    // Random stream with random valid/ready.
    base_s = n_sent;
    base_r = n_recv;
    cyc    = 0;
    while ((n_sent - base_s) < 1000 && cyc < 30000) begin
      v = W'($urandom);
      v = v >> $urandom_range(0, 8);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.data_in   = v;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("stream_accepted", 32'((n_sent - base_s) >= 1000), 32'd1);
    check("stream_drained",  32'(exp_q.size()), 32'd0);
    check("stream_recv_eq_sent", 32'(n_recv - base_r), 32'(n_sent - base_s));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/iter_normalizer.md
ITER_NORMALIZER -- requirements
Module: iter_normalizer

Interface
REQ-001 Parameter: WIDTH, default 8, data width; SHALL be a power of two, >= 4.
REQ-002 Derived constant: LOG2 = $clog2(WIDTH); number of iteration stages and shift-count width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  data_in valid.
REQ-006 in_ready  output  1  block can accept a new word.
REQ-007 data_in  input  WIDTH  unsigned word to normalize.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 data_out  output  WIDTH  data_in logically left-shifted so MSB = 1, zero-filled from LSB.
REQ-011 shift_amt  output  LOG2  left-shift distance applied, i.e. leading-zero count of data_in.
REQ-012 zero  output  1  data_in was all zeros.

Function
REQ-013 Block SHALL implement FSM with states IDLE, BUSY, DONE; exactly one active at a time.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: in_valid && in_ready at an edge -> latch data_in into work register, clear shift count, clear stage counter, go to BUSY.
REQ-016 BUSY SHALL perform one stage per cycle, stage distances S = WIDTH/2, WIDTH/4, ..., 1 in that order.
REQ-017 Each stage: if top S bits of work register are all zero -> work <<= S (zero fill), count += S; else no change.
REQ-018 After LOG2 BUSY cycles FSM SHALL enter DONE; out_valid first high LOG2 cycles after the accepting edge (WIDTH=8: 3 cycles).
REQ-019 Count arithmetic SHALL be LOG2 bits wide; maximum reachable value WIDTH-1, no overflow possible.
REQ-020 All-zero input: data_out = 0, shift_amt = WIDTH-1, zero = 1 (natural result of REQ-017, no special path for data/count).
REQ-021 Non-zero input: zero = 0, data_out[WIDTH-1] = 1.
REQ-022 MSB already set: shift_amt = 0, data_out = data_in.
REQ-023 In DONE, data_out, shift_amt, zero SHALL hold stable until out_valid && out_ready.
REQ-024 On output handshake FSM SHALL return to IDLE; in_ready rises the following cycle (no same-cycle output-handshake plus input-accept).
REQ-025 in_valid and data_in SHALL be ignored in BUSY and DONE; no queueing.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 data_out, shift_amt, zero SHALL be registered outputs; in IDLE/BUSY their values are don't-care but SHALL not contain X after reset.

Reset
REQ-028 rst = 1 at an edge SHALL force IDLE, in_ready = 1 after the edge, out_valid = 0, data_out = 0, shift_amt = 0, zero = 0, stage counter = 0.
REQ-029 rst SHALL take priority over any handshake in the same cycle, including mid-BUSY and in DONE; the in-flight word is discarded.
REQ-030 First accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-031 WIDTH=8, data_in 0x13 accepted, out_ready=1 -> out_valid 3 cycles later, data_out 0x98, shift_amt 3, zero 0; in_ready high the cycle after.
REQ-032 data_in 0x01 -> data_out 0x80, shift_amt 7, zero 0; data_in 0x80 -> data_out 0x80, shift_amt 0.
REQ-033 data_in 0x00 -> data_out 0x00, shift_amt 7, zero 1.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs and out_valid constant; in_valid pulses with 0xFF ignored; release -> one handshake, then IDLE.
REQ-035 Reset mid-BUSY (after stage 1 of 0x01) -> next cycle IDLE, out_valid 0, outputs 0; next accept of 0x40 -> shift_amt 1, data_out 0x80.
REQ-036 Back-to-back random stream (>=1000 words, random in_valid/out_ready) -> every result matches leading-zero reference model, no word dropped or duplicated.
